// File: rtl/ip2_testx_scanchain_reg_if.sv
// Bus bundle for the firmware-side scan-chain image: sequencer strobes,
// ASIC scan_out, pattern write port, readback port and shift status.
interface ip2_testx_scanchain_reg_if #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned CNT_W  = 10
);
    logic              enable;
    logic              scanchain_reg_load;
    logic              scanchain_reg_shift;
    logic              scan_out;
    logic              pat_wr_en;
    logic [4:0]        pat_wr_addr;
    logic [WORD_W-1:0] pat_wr_data;
    logic [4:0]        cap_rd_addr;
    logic [WORD_W-1:0] cap_rd_data;
    logic              scanchain_reg_bit0;
    logic [CNT_W-1:0]  scanchain_reg_shift_cnt;
    logic [CNT_W-1:0]  scanchain_reg_shift_cnt_max;
    logic              scanchain_reg_full;

    // Sequencer / firmware side
    modport master (
        output enable, scanchain_reg_load, scanchain_reg_shift, scan_out,
               pat_wr_en, pat_wr_addr, pat_wr_data, cap_rd_addr,
        input  cap_rd_data, scanchain_reg_bit0, scanchain_reg_shift_cnt,
               scanchain_reg_shift_cnt_max, scanchain_reg_full
    );

    // Scan-chain register side
    modport slave (
        input  enable, scanchain_reg_load, scanchain_reg_shift, scan_out,
               pat_wr_en, pat_wr_addr, pat_wr_data, cap_rd_addr,
        output cap_rd_data, scanchain_reg_bit0, scanchain_reg_shift_cnt,
               scanchain_reg_shift_cnt_max, scanchain_reg_full
    );
endinterface

// File: rtl/ip2_testx_scanchain_reg.sv
// 768-bit firmware image of the ASIC scan chain. A software-written pattern
// is copied into a right-shifting register on the sequencer load strobe; each
// shift strobe drives bit0 towards the ASIC and captures the synchronised
// ASIC scan_out at the MSB. Readback is word-wise from the live register.
module ip2_testx_scanchain_reg #(
    parameter int unsigned CHAIN_W = 768,
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned NWORDS  = 24,
    parameter int unsigned CNT_W   = 10
) (
    input logic                       clk,
    input logic                       reset_not,
    ip2_testx_scanchain_reg_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHAIN_W);

    logic [CHAIN_W-1:0] pat_q;
    logic [CHAIN_W-1:0] shreg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sync1_q;
    logic               sync2_q;
    logic [WORD_W-1:0]  rd_word;
    logic [WORD_W-1:0]  rd_data_q;

    // Pattern buffer: word writes accepted independent of enable; out-of-range addresses match no word
    always_ff @(posedge clk or negedge reset_not) begin
        if (!reset_not) begin
            pat_q <= '0;
        end else if (bus.pat_wr_en) begin
            for (int unsigned w = 0; w < NWORDS; w++) begin
                if (bus.pat_wr_addr == 5'(w)) begin
                    pat_q[w*WORD_W +: WORD_W] <= bus.pat_wr_data;
                end
            end
        end
    end

    // Two-flop synchroniser for the asynchronous ASIC scan_out
    always_ff @(posedge clk or negedge reset_not) begin
        if (!reset_not) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.scan_out;
            sync2_q <= sync1_q;
        end
    end

    // Shift register and count: load has priority over shift; shifting stops once the count saturates
    always_ff @(posedge clk or negedge reset_not) begin
        if (!reset_not) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (bus.enable) begin
            if (bus.scanchain_reg_load) begin
                shreg_q <= pat_q;
                cnt_q   <= '0;
            end else if (bus.scanchain_reg_shift && (cnt_q < CNT_MAX)) begin
                shreg_q <= {sync2_q, shreg_q[CHAIN_W-1:1]};
                cnt_q   <= cnt_q + 1'b1;
            end
        end
    end

    // Readback word select; addresses beyond the last word read as zero
    always_comb begin
        rd_word = '0;
        for (int unsigned w = 0; w < NWORDS; w++) begin
            if (bus.cap_rd_addr == 5'(w)) begin
                rd_word = shreg_q[w*WORD_W +: WORD_W];
            end
        end
    end

    // Registered readback of the live shift register
    always_ff @(posedge clk or negedge reset_not) begin
        if (!reset_not) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_word;
        end
    end

    assign bus.cap_rd_data                 = rd_data_q;
    assign bus.scanchain_reg_bit0          = shreg_q[0];
    assign bus.scanchain_reg_shift_cnt     = cnt_q;
    assign bus.scanchain_reg_shift_cnt_max = CNT_MAX;
    assign bus.scanchain_reg_full          = (cnt_q == CNT_MAX);
endmodule

// File: tb/tb_ip2_testx_scanchain_reg.sv
// Scoreboard bench for ip2_testx_scanchain_reg: stimulus pushes expected
// values tagged with the cycle they become visible; a negedge monitor pops
// and compares them against the DUT outputs.
module tb_ip2_testx_scanchain_reg;
  localparam int unsigned CHAIN_W = 768;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned NWORDS  = 24;
  localparam int unsigned CNT_W   = 10;

  localparam int K_RD   = 0;
  localparam int K_BIT0 = 1;
  localparam int K_CNT  = 2;
  localparam int K_FULL = 3;
  localparam int K_MAX  = 4;

  typedef struct {
    int          id;
    int          kind;
    logic [31:0] exp;
    longint      due;
  } chk_t;

  logic   clk       = 1'b0;
  logic   reset_not = 1'b0;
  logic   loop_en   = 1'b0;
  logic   scan_drv  = 1'b0;
  longint cycle     = 0;
  chk_t   sb[$];
  int     n_pass    = 0;
  int     n_total   = 0;
  int     n_id      = 0;

  always #5 clk = ~clk;

  ip2_testx_scanchain_reg_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

  ip2_testx_scanchain_reg #(
    .CHAIN_W(CHAIN_W),
    .WORD_W (WORD_W),
    .NWORDS (NWORDS),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .reset_not(reset_not),
    .bus      (bus)
  );

  assign bus.scan_out = loop_en ? bus.scanchain_reg_bit0 : scan_drv;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic string kname(int k);
    case (k)
      K_RD:    return "cap_rd_data";
      K_BIT0:  return "bit0";
      K_CNT:   return "shift_cnt";
      K_FULL:  return "full";
      default: return "shift_cnt_max";
    endcase
  endfunction

  // Monitor: compare every expectation whose visibility cycle has arrived
  always @(negedge clk) begin : mon
    logic [31:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cycle) begin
        case (sb[i].kind)
          K_RD:    act = bus.cap_rd_data;
          K_BIT0:  act = {31'd0, bus.scanchain_reg_bit0};
          K_CNT:   act = {22'd0, bus.scanchain_reg_shift_cnt};
          K_FULL:  act = {31'd0, bus.scanchain_reg_full};
          default: act = {22'd0, bus.scanchain_reg_shift_cnt_max};
        endcase
        n_total++;
        if (act === sb[i].exp) n_pass++;
        else $display("FAIL chk%0d %s got=0x%08h exp=0x%08h t=%0t",
                      sb[i].id, kname(sb[i].kind), act, sb[i].exp, $time);
        sb.delete(i);
      end
    end
  end

  task automatic expect_val(input int kind, input logic [31:0] exp, input longint delay);
    chk_t c;
    c.id   = n_id;
    c.kind = kind;
    c.exp  = exp;
    c.due  = cycle + delay;
    n_id++;
    sb.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [4:0] addr, input logic [31:0] data);
    bus.pat_wr_en   = 1'b1;
    bus.pat_wr_addr = addr;
    bus.pat_wr_data = data;
    tick();
    bus.pat_wr_en   = 1'b0;
  endtask

  task automatic pulse_load();
    bus.scanchain_reg_load = 1'b1;
    tick();
    bus.scanchain_reg_load = 1'b0;
  endtask

  task automatic shift_n(input int unsigned n, input int unsigned gap);
    for (int unsigned s = 0; s < n; s++) begin
      bus.scanchain_reg_shift = 1'b1;
      tick();
      bus.scanchain_reg_shift = 1'b0;
      repeat (gap - 1) tick();
    end
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] exp);
    bus.cap_rd_addr = addr;
    expect_val(K_RD, exp, 1);
    tick();
  endtask

  task automatic status(input logic [9:0] cnt, input logic b0, input logic full);
    expect_val(K_CNT,  {22'd0, cnt}, 0);
    expect_val(K_BIT0, {31'd0, b0}, 0);
    expect_val(K_FULL, {31'd0, full}, 0);
  endtask

  // Watchdog bound on the whole run
  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.enable              = 1'b1;
    bus.scanchain_reg_load  = 1'b0;
    bus.scanchain_reg_shift = 1'b0;
    bus.pat_wr_en           = 1'b0;
    bus.pat_wr_addr         = '0;
    bus.pat_wr_data         = '0;
    bus.cap_rd_addr         = '0;

    // Reset state
    repeat (3) tick();
    reset_not = 1'b1;
    tick();
    status(10'd0, 1'b0, 1'b0);
    expect_val(K_MAX, 32'd768, 0);
    n_total++;
    if (bus.scanchain_reg_shift_cnt_max === 10'd768) n_pass++;
    else $display("FAIL direct shift_cnt_max got=%0d exp=768", bus.scanchain_reg_shift_cnt_max);
    rd(5'd0, 32'h0);

    // Load and first shifts
    write_word(5'd0, 32'h0000_0005);
    for (int unsigned w = 1; w < 24; w++) write_word(5'(w), 32'h0);
    pulse_load();
    status(10'd0, 1'b1, 1'b0);
    shift_n(1, 1);
    status(10'd1, 1'b0, 1'b0);
    shift_n(1, 1);
    status(10'd2, 1'b1, 1'b0);
    rd(5'd0, 32'h0000_0001);
    rd(5'd23, 32'h0);

    // Disabled: strobes ignored, pattern writes still accepted
    bus.enable = 1'b0;
    write_word(5'd1, 32'h0BAD_F00D);
    pulse_load();
    shift_n(3, 4);
    status(10'd2, 1'b1, 1'b0);
    bus.enable = 1'b1;
    rd(5'd0, 32'h0000_0001);
    pulse_load();
    status(10'd0, 1'b1, 1'b0);
    rd(5'd1, 32'h0BAD_F00D);

    // Loopback rotation through the synchroniser
    for (int unsigned w = 0; w < 24; w++) write_word(5'(w), 32'hA5A5_0000 + 32'(w));
    loop_en = 1'b1;
    pulse_load();
    status(10'd0, 1'b0, 1'b0);
    repeat (4) tick();
    shift_n(32, 8);
    expect_val(K_CNT, 32'd32, 0);
    rd(5'd0, 32'hA5A5_0001);
    rd(5'd23, 32'hA5A5_0000);
    shift_n(736, 8);
    status(10'd768, 1'b0, 1'b1);
    n_total++;
    if (bus.scanchain_reg_full === 1'b1 && bus.scanchain_reg_shift_cnt === 10'd768) n_pass++;
    else $display("FAIL direct full/cnt got full=%b cnt=%0d", bus.scanchain_reg_full,
                  bus.scanchain_reg_shift_cnt);
    for (int unsigned w = 0; w < 24; w++) rd(5'(w), 32'hA5A5_0000 + 32'(w));
    shift_n(1, 8);
    status(10'd768, 1'b0, 1'b1);
    n_total++;
    if (bus.scanchain_reg_shift_cnt === 10'd768) n_pass++;
    else $display("FAIL direct saturated cnt got=%0d", bus.scanchain_reg_shift_cnt);
    rd(5'd0, 32'hA5A5_0000);
    rd(5'd23, 32'hA5A5_0017);

    // Simultaneous load + shift at count 100, with a same-cycle pattern write
    pulse_load();
    repeat (4) tick();
    shift_n(100, 4);
    expect_val(K_CNT, 32'd100, 0);
    bus.scanchain_reg_load  = 1'b1;
    bus.scanchain_reg_shift = 1'b1;
    bus.pat_wr_en           = 1'b1;
    bus.pat_wr_addr         = 5'd0;
    bus.pat_wr_data         = 32'h1234_5678;
    tick();
    bus.scanchain_reg_load  = 1'b0;
    bus.scanchain_reg_shift = 1'b0;
    bus.pat_wr_en           = 1'b0;
    status(10'd0, 1'b0, 1'b0);
    rd(5'd0, 32'hA5A5_0000);
    rd(5'd5, 32'hA5A5_0005);
    rd(5'd23, 32'hA5A5_0017);
    pulse_load();
    rd(5'd0, 32'h1234_5678);

    // Out-of-range write and readback addresses
    write_word(5'd24, 32'hFFFF_FFFF);
    write_word(5'd31, 32'hFFFF_FFFF);
    pulse_load();
    rd(5'd0, 32'h1234_5678);
    rd(5'd1, 32'hA5A5_0001);
    rd(5'd23, 32'hA5A5_0017);
    rd(5'd30, 32'h0);
    rd(5'd24, 32'h0);

    // Capture of a constant-1 scan_out
    loop_en  = 1'b0;
    scan_drv = 1'b1;
    for (int unsigned w = 0; w < 24; w++) write_word(5'(w), 32'h0);
    pulse_load();
    expect_val(K_BIT0, 32'd0, 0);
    repeat (4) tick();
    shift_n(768, 4);
    status(10'd768, 1'b1, 1'b1);
    for (int unsigned w = 0; w < 24; w++) rd(5'(w), 32'hFFFF_FFFF);

    // Capture with scan_out low for the last 32 shifts only
    pulse_load();
    rd(5'd0, 32'h0);
    shift_n(736, 4);
    scan_drv = 1'b0;
    repeat (4) tick();
    shift_n(32, 4);
    expect_val(K_CNT, 32'd768, 0);
    for (int unsigned w = 0; w < 24; w++) rd(5'(w), (w == 23) ? 32'h0 : 32'hFFFF_FFFF);

    // Asynchronous reset in the middle of shifting
    write_word(5'd0, 32'hFFFF_FFFF);
    pulse_load();
    shift_n(10, 4);
    status(10'd10, 1'b1, 1'b0);
    bus.cap_rd_addr         = 5'd0;
    bus.scanchain_reg_shift = 1'b1;
    @(posedge clk);
    #2;
    reset_not               = 1'b0;
    bus.scanchain_reg_shift = 1'b0;
    status(10'd0, 1'b0, 1'b0);
    expect_val(K_RD, 32'h0, 0);
    expect_val(K_MAX, 32'd768, 0);
    repeat (3) tick();
    reset_not = 1'b1;
    tick();
    rd(5'd0, 32'h0);
    pulse_load();
    status(10'd0, 1'b0, 1'b0);
    rd(5'd0, 32'h0);
    expect_val(K_MAX, 32'd768, 0);
    n_total++;
    if (bus.scanchain_reg_shift_cnt_max === 10'd768) n_pass++;
    else $display("FAIL direct shift_cnt_max after reset got=%0d", bus.scanchain_reg_shift_cnt_max);

    repeat (4) tick();
    foreach (sb[i]) begin
      n_total++;
      $display("FAIL chk%0d %s never sampled (exp=0x%08h)", sb[i].id, kname(sb[i].kind), sb[i].exp);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ip2_testx_scanchain_reg.md
Name: ip2_testx_scanchain_reg

Overview:
- Firmware-side 768-bit image of the ASIC scan chain, sitting directly beside the test1 sequencer.
- Holds a software-written pattern and, on the sequencer's load strobe, copies it into a shift register.
- On each shift strobe it shifts right: bit0 feeds the sequencer's scan_in drive, and the sampled ASIC scan_out enters at the MSB.
- Provides the shift count and count limit that end the sequencer's SHIFT_IN phase, plus word-wise readback of the captured chain.

Parameters:
- CHAIN_W, 768: scan-chain length in bits.
- WORD_W, 32: software word width.
- NWORDS, 24: CHAIN_W/WORD_W; number of pattern and readback words.
- CNT_W, 10: shift counter width; must hold CHAIN_W.

Ports:
- clk  in  1  FW clock, 400 MHz (pl_clk1).
- reset_not  in  1  asynchronous, active-low reset.
- enable  in  1  block enable; when low, strobes are ignored and state holds.
- scanchain_reg_load  in  1  from sequencer: copy pattern into shift register.
- scanchain_reg_shift  in  1  from sequencer: one right shift.
- scan_out  in  1  ASIC scan-chain serial output (asynchronous to clk).
- pat_wr_en  in  1  pattern buffer write strobe.
- pat_wr_addr  in  5  pattern word index.
- pat_wr_data  in  WORD_W  pattern word.
- cap_rd_addr  in  5  readback word index.
- cap_rd_data  out  WORD_W  readback word, shift register bits [addr*32+31 : addr*32].
- scanchain_reg_bit0  out  1  shift register bit 0.
- scanchain_reg_shift_cnt  out  CNT_W  completed shifts since last load.
- scanchain_reg_shift_cnt_max  out  CNT_W  constant CHAIN_W (768).
- scanchain_reg_full  out  1  high when shift_cnt == shift_cnt_max.

Behaviour:
- Reset (reset_not low, asynchronous): pattern buffer = 0, shift register = 0, shift_cnt = 0, synchroniser flops = 0, cap_rd_data = 0, bit0 = 0, full = 0. shift_cnt_max is a constant, unaffected by reset.
- Reset released mid-operation: everything returns to reset values; the next load restarts cleanly.
- Pattern buffer:
  - pat_wr_en with addr < NWORDS writes word[addr] at the next clk edge.
  - addr >= NWORDS is ignored.
  - Writes are accepted regardless of enable.
  - Writes do not disturb the shift register.
- scan_out synchroniser: 2-flop synchroniser; the shifted-in bit is the synchroniser's second-stage value at the shift edge.
- All remaining behaviour requires enable = 1.
- Load (scanchain_reg_load = 1): at the next edge, shift register <= full pattern buffer and shift_cnt <= 0. A pattern write in the same cycle is NOT included in the loaded image; the buffer updates in that cycle.
- Shift (scanchain_reg_shift = 1, load = 0, shift_cnt < CHAIN_W): at the next edge, shift register <= {scan_out_sync, reg[CHAIN_W-1:1]} and shift_cnt <= shift_cnt + 1.
- Shift when shift_cnt == CHAIN_W: no shift and no count change (saturates).
- Load and shift in the same cycle: load wins and the shift is dropped.
- Latency:
  - bit0 and shift_cnt update 1 clk after the strobe.
  - The sequencer accounts for 2 clk in total, including its own register stage.
- bit0 and full are combinational from the registers.
- Readback:
  - cap_rd_data is registered, valid 1 clk after cap_rd_addr.
  - addr >= NWORDS returns 0.
  - Readback reflects the live shift register at all times, including mid-shift.
- enable = 0: load and shift are ignored, and the registers and count hold their values.
- After exactly CHAIN_W shifts the register holds the full captured ASIC response in its original bit order: the first bit out of the ASIC lands in bit 0.

Test Plan:
- Reset: drive reset_not low mid-shift -> reg = 0, shift_cnt = 0, bit0 = 0, full = 0, cap_rd_data = 0; shift_cnt_max = 768 throughout.
- Load: write word0 = 0x0000_0005 and the other words 0, pulse load -> bit0 = 1 and shift_cnt = 0 next clk; one shift with scan_out = 0 -> bit0 = 0; a second shift -> bit0 = 1.
- Loopback: pattern words = 0xA5A5_0000 + i, with scan_out fed from bit0 through 2 cycles of delay matching the synchroniser; pulse load, then 768 shifts spaced 8 clk apart -> shift_cnt = 768, full = 1, all 24 readback words equal the pattern; a 769th shift leaves the count at 768 and the register unchanged.
- Simultaneous load and shift, with shift_cnt = 100 -> shift_cnt = 0 and reg = pattern, no shift.
- Disabled and out-of-range accesses:
  - enable = 0 with load and shift pulses -> register and count unchanged.
  - pat_wr_addr = 24 write -> buffer unchanged.
  - cap_rd_addr = 30 -> 0.
- Capture: pattern all-zero, scan_out held at 1 for 768 shifts -> every readback word = 0xFFFF_FFFF. Drop scan_out to 0 for the last 32 shifts only -> word 23 = 0x0000_0000, all other words 0xFFFF_FFFF.
